// File: rtl/mac_pkg.sv
// Shared widths, derived sizes, saturation limits and FIFO entry type for the
// post-MAC requantisation stage.
package mac_pkg;

    localparam int unsigned WEIGHT_WIDTH  = 16;
    localparam int unsigned FEATURE_WIDTH = 16;
    localparam int unsigned ACC_WIDTH     = WEIGHT_WIDTH + FEATURE_WIDTH + 1;
    localparam int unsigned SHIFT_WIDTH   = 5;
    localparam int unsigned FIFO_DEPTH    = 4;

    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);

    // Wide enough that bias << shift plus the accumulator can never overflow.
    function automatic int unsigned calc_sum_width(input int unsigned acc_w,
                                                   input int unsigned feat_w,
                                                   input int unsigned shift_w);
        int unsigned biased_w;
        biased_w = feat_w + (32'd1 << shift_w) - 1;
        return ((acc_w > biased_w) ? acc_w : biased_w) + 1;
    endfunction

    localparam int unsigned SUM_WIDTH = calc_sum_width(ACC_WIDTH, FEATURE_WIDTH, SHIFT_WIDTH);
    // One extra bit so the rounding increment cannot wrap.
    localparam int unsigned R_WIDTH   = SUM_WIDTH + 1;

    localparam logic [FEATURE_WIDTH-1:0] SAT_MAX = {1'b0, {(FEATURE_WIDTH-1){1'b1}}};
    localparam logic [FEATURE_WIDTH-1:0] SAT_MIN = {1'b1, {(FEATURE_WIDTH-1){1'b0}}};

    localparam logic signed [R_WIDTH-1:0] SAT_MAX_EXT =
        {{(R_WIDTH-FEATURE_WIDTH){1'b0}}, SAT_MAX};
    localparam logic signed [R_WIDTH-1:0] SAT_MIN_EXT =
        {{(R_WIDTH-FEATURE_WIDTH){1'b1}}, SAT_MIN};

    typedef struct packed {
        logic [FEATURE_WIDTH-1:0] data;
        logic                     sat;
    } fifo_entry_t;

endpackage

// File: rtl/mac_requant_fifo.sv
// Small synchronous FIFO for requantised results. Head is read combinationally
// and forced to zero when the FIFO is empty.
module mac_requant_fifo
    import mac_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  fifo_entry_t          wdata,
    input  logic                 pop,
    output fifo_entry_t          rdata,
    output logic                 valid,
    output logic [CNT_WIDTH-1:0] count
);

    fifo_entry_t          mem_q [FIFO_DEPTH];
    fifo_entry_t          mem_d [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 do_pop;

    // Next-state for storage, pointers and occupancy; push into a full FIFO is
    // only legal alongside a pop, which upstream credits guarantee.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && (count_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
        count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(do_pop);
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head output, zeroed when empty.
    always_comb begin
        valid = (count_q != '0);
        rdata = valid ? mem_q[rd_ptr_q] : '0;
        count = count_q;
    end

endmodule

// File: rtl/mac_requant.sv
// Requantisation of MAC accumulator results: bias add, rounding right shift,
// optional ReLU, saturation, then a credit-flow-controlled output FIFO.
module mac_requant
    import mac_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ACC_WIDTH-1:0]     acc_in,
    input  logic                     acc_valid,
    output logic                     acc_ready,
    input  logic [FEATURE_WIDTH-1:0] bias,
    input  logic [SHIFT_WIDTH-1:0]   shift,
    input  logic                     relu_en,
    output logic [FEATURE_WIDTH-1:0] out_data,
    output logic                     out_sat,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     ovf_clr,
    output logic                     overflow
);

    logic accept;
    logic drop;

    // Stage 1 state
    logic signed [SUM_WIDTH-1:0]   sum_q, sum_d;
    logic [SHIFT_WIDTH-1:0]        shift_q, shift_d;
    logic                          relu1_q, relu1_d;
    logic                          v1_q, v1_d;
    logic signed [SUM_WIDTH-1:0]   acc_ext, bias_ext;

    // Stage 2 state
    logic signed [R_WIDTH-1:0]     r_q, r_d;
    logic                          relu2_q, relu2_d;
    logic                          v2_q, v2_d;
    logic signed [R_WIDTH-1:0]     r_ext, rnd;

    logic                          overflow_q, overflow_d;
    logic [CNT_WIDTH:0]            occupancy;
    logic [CNT_WIDTH-1:0]          fifo_count;
    fifo_entry_t                   wr_entry;
    fifo_entry_t                   head;
    logic                          fifo_valid;

    // Credits: every accepted sample that has not yet left the FIFO holds one slot.
    always_comb begin
        occupancy = {1'b0, fifo_count} + (CNT_WIDTH+1)'(v1_q) + (CNT_WIDTH+1)'(v2_q);
        acc_ready = occupancy < (CNT_WIDTH+1)'(FIFO_DEPTH);
        accept    = acc_valid && acc_ready;
        drop      = acc_valid && !acc_ready;
    end

    // Stage 1: sign-extend and add the bias pre-scaled to the accumulator's fixed point.
    always_comb begin
        acc_ext  = {{(SUM_WIDTH-ACC_WIDTH){acc_in[ACC_WIDTH-1]}}, acc_in};
        bias_ext = {{(SUM_WIDTH-FEATURE_WIDTH){bias[FEATURE_WIDTH-1]}}, bias};
        sum_d    = sum_q;
        shift_d  = shift_q;
        relu1_d  = relu1_q;
        v1_d     = accept;
        if (accept) begin
            sum_d   = acc_ext + (bias_ext <<< shift);
            shift_d = shift;
            relu1_d = relu_en;
        end
    end

    // Stage 2: arithmetic right shift with round-half-up.
    always_comb begin
        r_ext   = {sum_q[SUM_WIDTH-1], sum_q};
        rnd     = '0;
        r_d     = r_q;
        relu2_d = relu2_q;
        v2_d    = v1_q;
        if (v1_q) begin
            relu2_d = relu1_q;
            if (shift_q == '0) begin
                r_d = r_ext;
            end else begin
                rnd = {{(R_WIDTH-1){1'b0}}, 1'b1} << (shift_q - SHIFT_WIDTH'(1));
                r_d = (r_ext + rnd) >>> shift_q;
            end
        end
    end

    // Stage 3: ReLU then saturate; result goes straight into the FIFO.
    always_comb begin
        wr_entry = '0;
        if (relu2_q && r_q[R_WIDTH-1]) begin
            wr_entry = '0;
        end else if (r_q > SAT_MAX_EXT) begin
            wr_entry.data = SAT_MAX;
            wr_entry.sat  = 1'b1;
        end else if (r_q < SAT_MIN_EXT) begin
            wr_entry.data = SAT_MIN;
            wr_entry.sat  = 1'b1;
        end else begin
            wr_entry.data = r_q[FEATURE_WIDTH-1:0];
            wr_entry.sat  = 1'b0;
        end
    end

    // Sticky drop flag; a new drop wins over a clear in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Pipeline and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q      <= '0;
            shift_q    <= '0;
            relu1_q    <= 1'b0;
            v1_q       <= 1'b0;
            r_q        <= '0;
            relu2_q    <= 1'b0;
            v2_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            shift_q    <= shift_d;
            relu1_q    <= relu1_d;
            v1_q       <= v1_d;
            r_q        <= r_d;
            relu2_q    <= relu2_d;
            v2_q       <= v2_d;
            overflow_q <= overflow_d;
        end
    end

    mac_requant_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (v2_q),
        .wdata (wr_entry),
        .pop   (out_ready),
        .rdata (head),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    // Output mapping.
    always_comb begin
        out_data  = head.data;
        out_sat   = head.sat;
        out_valid = fifo_valid;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_mac_requant.sv
// Randomised and directed bench for mac_requant against a transaction-level model.
module tb_mac_requant;
    import mac_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [ACC_WIDTH-1:0]     acc_in;
    logic                     acc_valid;
    logic                     acc_ready;
    logic [FEATURE_WIDTH-1:0] bias;
    logic [SHIFT_WIDTH-1:0]   shift;
    logic                     relu_en;
    logic [FEATURE_WIDTH-1:0] out_data;
    logic                     out_sat;
    logic                     out_valid;
    logic                     out_ready;
    logic                     ovf_clr;
    logic                     overflow;

    mac_requant dut (
        .clk       (clk),
        .reset     (reset),
        .acc_in    (acc_in),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .bias      (bias),
        .shift     (shift),
        .relu_en   (relu_en),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        sat;
        int          vis;
    } exp_t;

    exp_t   exp_q[$];
    int     cyc;
    bit     m_ovf;
    int     checks;
    int     errors;

    longint cur_a;
    longint cur_b;
    int     cur_sh;
    bit     cur_relu;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Plain integer arithmetic: result = round_half_up((acc + bias*2^sh) / 2^sh).
    function automatic void ref_calc(input longint a, input longint b, input int sh,
                                     input bit relu, output logic [15:0] d, output logic s);
        longint sum;
        longint r;
        sum = a + b * (longint'(1) << sh);
        if (sh == 0) r = sum;
        else r = (sum + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && r < 0) begin
            d = 16'd0; s = 1'b0;
        end else if (r > 32767) begin
            d = 16'h7fff; s = 1'b1;
        end else if (r < -32768) begin
            d = 16'h8000; s = 1'b1;
        end else begin
            d = 16'(r); s = 1'b0;
        end
    endfunction

    task automatic drive(input bit v, input longint a, input longint b, input int sh,
                         input bit relu);
        acc_valid = v;
        cur_a     = a;
        cur_b     = b;
        cur_sh    = sh;
        cur_relu  = relu;
        acc_in    = ACC_WIDTH'(a);
        bias      = FEATURE_WIDTH'(b);
        shift     = SHIFT_WIDTH'(sh);
        relu_en   = relu;
    endtask

    // Compare outputs with the model, then advance one clock and update the model.
    task automatic step();
        bit          m_rdy;
        bit          m_vld;
        bit          acc;
        bit          pop;
        exp_t        e;
        m_rdy = exp_q.size() < FIFO_DEPTH;
        m_vld = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
        check("acc_ready", 32'(acc_ready), 32'(m_rdy));
        check("out_valid", 32'(out_valid), 32'(m_vld));
        check("out_data", 32'(out_data), m_vld ? 32'(exp_q[0].data) : 32'd0);
        check("out_sat", 32'(out_sat), m_vld ? 32'(exp_q[0].sat) : 32'd0);
        check("overflow", 32'(overflow), 32'(m_ovf));
        acc = acc_valid && m_rdy;
        pop = m_vld && out_ready;
        ref_calc(cur_a, cur_b, cur_sh, cur_relu, e.data, e.sat);
        @(posedge clk);
        #1;
        cyc++;
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            e.vis = cyc + 2;
            exp_q.push_back(e);
        end
        if (acc_valid && !m_rdy) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 0, 1'b0);
    endtask

    // One sample held in the FIFO; literal expectation after the 3rd edge.
    task automatic directed(input string tag, input longint a, input longint b, input int sh,
                            input bit relu, input logic [15:0] exp_d, input logic exp_s);
        out_ready = 1'b0;
        drive(1'b1, a, b, sh, relu);
        step();
        idle();
        step();
        check({tag, "_early"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        logic [63:0] raw;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        m_ovf     = 1'b0;
        reset     = 1'b1;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc_ready", 32'(acc_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        directed("t1", 1000, 0, 0, 1'b0, 16'd1000, 1'b0);
        directed("rnd_up", 760, 1, 4, 1'b0, 16'd49, 1'b0);
        directed("rnd_neg", -24, 0, 4, 1'b0, 16'hffff, 1'b0);
        directed("sat_pos", 40000, 0, 0, 1'b0, 16'h7fff, 1'b1);
        directed("sat_neg", -40000, 0, 0, 1'b0, 16'h8000, 1'b1);
        directed("relu", -40000, 0, 0, 1'b1, 16'd0, 1'b0);

        // Backpressure: four accepted, fifth dropped.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, i, 0, 0, 1'b0);
            if (i == 5) check("bp_ready_low", 32'(acc_ready), 32'd0);
            step();
        end
        idle();
        check("bp_overflow", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("bp_drain_valid", 32'(out_valid), 32'd1);
            check("bp_drain_data", 32'(out_data), 32'(k));
            step();
        end
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_ovf_sticky", 32'(overflow), 32'd1);

        // Clear, then clear coinciding with a drop.
        ovf_clr = 1'b1;
        step();
        check("clr_alone", 32'(overflow), 32'd0);
        ovf_clr   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 10 + i, 0, 0, 1'b0);
            step();
        end
        drive(1'b1, 99, 0, 0, 1'b0);
        ovf_clr = 1'b1;
        step();
        check("clr_vs_drop", 32'(overflow), 32'd1);
        idle();
        step();
        check("clr_next", 32'(overflow), 32'd0);
        ovf_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();

        // Reset with two samples buffered and two in the pipeline.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 200 + i, 0, 0, 1'b0);
            step();
        end
        idle();
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(acc_ready), 32'd1);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        exp_q.delete();
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc  += 2;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            longint a;
            longint b;
            raw = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       a = longint'($signed(raw[32:0]));
                1:       a = longint'($urandom_range(0, 140000)) - 70000;
                default: a = longint'($urandom_range(0, 2000)) - 1000;
            endcase
            b = longint'($signed(raw[48:33]));
            if ($urandom_range(0, 3) == 0) b = 0;
            drive($urandom_range(0, 9) < 7, a, b, int'($urandom_range(0, 31)),
                  $urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 6);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            step();
        end
        idle();
        ovf_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
